// File: rtl/dtc_pkg.sv
// rtl/dtc_pkg.sv - shared types, constants and sizing helpers for the decision-tree evaluator
package dtc_pkg;

   typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

   localparam int ERR_CLASS = 0;

   localparam int DEF_N_FEAT    = 8;
   localparam int DEF_FEAT_W    = 1;
   localparam int DEF_CLASS_W   = 2;
   localparam int DEF_MAX_NODES = 32;

   function automatic int node_aw(input int max_nodes);
      return $clog2(max_nodes);
   endfunction

   // One extra code point so an out-of-range feature index can be stored and caught
   function automatic int fidx_w(input int n_feat);
      return $clog2(n_feat + 1);
   endfunction

   function automatic int node_w(input int n_feat, input int feat_w, input int class_w,
                                 input int max_nodes);
      return 1 + fidx_w(n_feat) + feat_w + 2 * node_aw(max_nodes) + class_w;
   endfunction

   // Node entry at the default widths; the evaluator rebuilds the same layout for its own widths
   typedef struct packed {
      logic                               leaf;
      logic [fidx_w(DEF_N_FEAT)-1:0]      feat;
      logic [DEF_FEAT_W-1:0]              thr;
      logic [node_aw(DEF_MAX_NODES)-1:0]  lo;
      logic [node_aw(DEF_MAX_NODES)-1:0]  hi;
      logic [DEF_CLASS_W-1:0]             cls;
   } node_t;

endpackage

// File: rtl/dtc_node_table.sv
// rtl/dtc_node_table.sv - reset-initialised node table, one write port and one async read port
module dtc_node_table #(
   parameter int            DEPTH   = 32,
   parameter int            W       = 18,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dtc_seq_eval.sv
// rtl/dtc_seq_eval.sv - sequential decision-tree walker, one table node per cycle
module dtc_seq_eval import dtc_pkg::*; #(
   parameter int N_FEAT    = 8,
   parameter int FEAT_W    = 1,
   parameter int CLASS_W   = 2,
   parameter int MAX_NODES = 32
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                in_valid,
   output logic                                                in_ready,
   input  logic [N_FEAT*FEAT_W-1:0]                            inp,
   output logic                                                out_valid,
   input  logic                                                out_ready,
   output logic [CLASS_W-1:0]                                  outp,
   output logic                                                out_err,
   input  logic                                                cfg_we,
   input  logic [$clog2(MAX_NODES)-1:0]                        cfg_addr,
   input  logic [node_w(N_FEAT, FEAT_W, CLASS_W, MAX_NODES)-1:0] cfg_node,
   output logic                                                cfg_busy
);

   localparam int NODE_AW = node_aw(MAX_NODES);
   localparam int FIDX_W  = fidx_w(N_FEAT);
   localparam int NODE_W  = node_w(N_FEAT, FEAT_W, CLASS_W, MAX_NODES);
   localparam int IN_W    = N_FEAT * FEAT_W;
   localparam logic [NODE_W-1:0] RST_NODE = {1'b1, {(NODE_W-1){1'b0}}};

   typedef struct packed {
      logic                leaf;
      logic [FIDX_W-1:0]   feat;
      logic [FEAT_W-1:0]   thr;
      logic [NODE_AW-1:0]  lo;
      logic [NODE_AW-1:0]  hi;
      logic [CLASS_W-1:0]  cls;
   } node_s;

   state_t              state;
   logic [NODE_AW-1:0]  ptr;
   logic [NODE_AW:0]    step;
   logic [NODE_AW:0]    step_nx;
   logic [IN_W-1:0]     feats;
   logic [NODE_W-1:0]   rd;
   node_s               nd;
   logic [IN_W-1:0]     sh;
   logic [FEAT_W-1:0]   fval;
   logic                feat_bad;
   logic                go_hi;
   logic                step_out;

   dtc_node_table #(
      .DEPTH   (MAX_NODES),
      .W       (NODE_W),
      .RST_VAL (RST_NODE)
   ) u_table (
      .clk   (clk),
      .rst   (rst),
      .we    (cfg_we && (state == IDLE)),
      .waddr (cfg_addr),
      .wdata (cfg_node),
      .raddr (ptr),
      .rdata (rd)
   );

   always_comb begin
      nd       = node_s'(rd);
      sh       = feats >> (FEAT_W * int'(nd.feat));
      fval     = sh[FEAT_W-1:0];
      feat_bad = (nd.feat >= FIDX_W'(N_FEAT));
      go_hi    = (fval > nd.thr);
      step_nx  = step + (NODE_AW+1)'(1);
      step_out = (step_nx == (NODE_AW+1)'(MAX_NODES));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         step    <= '0;
         feats   <= '0;
         outp    <= '0;
         out_err <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  feats <= inp;
                  ptr   <= '0;
                  step  <= '0;
                  state <= WALK;
               end
            end
            WALK: begin
               if (nd.leaf) begin
                  outp    <= nd.cls;
                  out_err <= 1'b0;
                  state   <= DONE;
               end else if (feat_bad || step_out) begin
                  // Bad feature index or a cycle in the table: abort with the error class
                  outp    <= CLASS_W'(ERR_CLASS);
                  out_err <= 1'b1;
                  state   <= DONE;
               end else begin
                  ptr  <= go_hi ? nd.hi : nd.lo;
                  step <= step_nx;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign cfg_busy  = (state != IDLE);

endmodule
